fb_stream_writer: RTL

FB_STREAM_WRITER -- requirements
Module: fb_stream_writer

---
 rtl/fb_pkg.sv | 30 +++
 rtl/fb_stream_writer_if.sv | 27 ++
 rtl/fb_addr_gen.sv | 81 ++++++++
 rtl/fb_stream_writer.sv | 135 +++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared types and constants for the framebuffer stream writer.
// Includes the FSM state, the address-generator commands and the err_o bit positions.
package fb_pkg;

    localparam int PIX_W = 24;
    localparam int ERR_W = 3;

    localparam int ERR_SHORT_LINE = 0;
    localparam int ERR_LONG_LINE  = 1;
    localparam int ERR_SOF_RESYNC = 2;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } fb_state_e;

    typedef enum logic [2:0] {
        CMD_HOLD      = 3'd0,
        CMD_RESTART   = 3'd1,
        CMD_STEP      = 3'd2,
        CMD_NEXT_LINE = 3'd3,
        CMD_FRAME_END = 3'd4
    } addr_cmd_e;

    // Bits needed to count 0..n inclusive (at least one bit).
    function automatic int cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/fb_stream_writer_if.sv
// Pixel stream input and framebuffer write port of the stream writer, bundled
// so a source/sink can be wired to the writer as one object.
interface fb_stream_writer_if
    import fb_pkg::*;
#(
    parameter int ADDR_BITS = 20
);
    logic                 s_valid;
    logic                 s_ready;
    logic [PIX_W-1:0]     s_data;
    logic                 s_sof;
    logic                 s_eol;
    logic                 hold;
    logic [ADDR_BITS-1:0] pxl_addr;
    logic [PIX_W-1:0]     pxl_data;
    logic                 pxl_en;

    modport master (
        output s_valid, s_data, s_sof, s_eol, hold,
        input  s_ready, pxl_addr, pxl_data, pxl_en
    );

    modport slave (
        input  s_valid, s_data, s_sof, s_eol, hold,
        output s_ready, pxl_addr, pxl_data, pxl_en
    );
endinterface

// File: rtl/fb_addr_gen.sv
// x / y / line_base tracker for the framebuffer writer; the address is
// line_base + x, with line_base stepping by FB_X so no multiplier is needed.
module fb_addr_gen
    import fb_pkg::*;
#(
    parameter int FB_X      = 1280,
    parameter int FB_Y      = 720,
    parameter int ADDR_BITS = $clog2(FB_X * FB_Y)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  addr_cmd_e            cmd_i,
    output logic                 x_in_line_o,
    output logic                 x_short_o,
    output logic                 last_line_o,
    output logic [ADDR_BITS-1:0] addr_o
);

    localparam int XW = cnt_w(FB_X);
    localparam int YW = cnt_w(FB_Y);

    localparam logic [XW-1:0]        X_LIM  = XW'(FB_X);
    localparam logic [YW-1:0]        Y_LAST = YW'(FB_Y - 1);
    localparam logic [ADDR_BITS-1:0] LINE_STEP = ADDR_BITS'(FB_X);

    logic [XW-1:0]        x_q, x_d;
    logic [YW-1:0]        y_q, y_d;
    logic [ADDR_BITS-1:0] lb_q, lb_d;

    always_comb begin
        x_d  = x_q;
        y_d  = y_q;
        lb_d = lb_q;
        case (cmd_i)
            CMD_RESTART: begin
                // The SOF pixel itself lands at address 0, so the next one is x=1.
                x_d  = XW'(1);
                y_d  = '0;
                lb_d = '0;
            end
            CMD_STEP: begin
                if (x_q < X_LIM) begin
                    x_d = x_q + XW'(1);
                end
            end
            CMD_NEXT_LINE: begin
                x_d  = '0;
                y_d  = y_q + YW'(1);
                lb_d = lb_q + LINE_STEP;
            end
            CMD_FRAME_END: begin
                x_d  = '0;
                y_d  = '0;
                lb_d = '0;
            end
            default: begin
                x_d  = x_q;
                y_d  = y_q;
                lb_d = lb_q;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            x_q  <= '0;
            y_q  <= '0;
            lb_q <= '0;
        end else begin
            x_q  <= x_d;
            y_q  <= y_d;
            lb_q <= lb_d;
        end
    end

    assign x_in_line_o = (x_q < X_LIM);
    assign x_short_o   = (x_q < (X_LIM - XW'(1)));
    assign last_line_o = (y_q == Y_LAST);
    assign addr_o      = lb_q + ADDR_BITS'(x_q);

endmodule

// File: rtl/fb_stream_writer.sv
// Writes a SOF/EOL-framed pixel stream into a FB_X x FB_Y framebuffer,
// flagging short lines, long lines and mid-frame SOF resyncs in sticky error bits.
module fb_stream_writer
    import fb_pkg::*;
#(
    parameter int FB_X      = 1280,
    parameter int FB_Y      = 720,
    parameter int ADDR_BITS = $clog2(FB_X * FB_Y)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 s_valid_i,
    output logic                 s_ready_o,
    input  logic [PIX_W-1:0]     s_data_i,
    input  logic                 s_sof_i,
    input  logic                 s_eol_i,
    input  logic                 hold_i,
    output logic [ADDR_BITS-1:0] pxl_addr_o,
    output logic [PIX_W-1:0]     pxl_data_o,
    output logic                 pxl_en_o,
    output logic                 frame_done_o,
    output logic [ERR_W-1:0]     err_o,
    input  logic                 err_clr_i
);

    fb_state_e            state_q, state_d;
    addr_cmd_e            cmd;
    logic                 accept;
    logic                 x_in_line, x_short, last_line;
    logic [ADDR_BITS-1:0] cur_addr;

    logic                 wr_d;
    logic [ADDR_BITS-1:0] wr_addr_d;
    logic                 fd_d;
    logic [ERR_W-1:0]     err_set, err_d;

    logic                 pxl_en_q, fd_q;
    logic [ADDR_BITS-1:0] pxl_addr_q;
    logic [PIX_W-1:0]     pxl_data_q;
    logic [ERR_W-1:0]     err_q;

    assign s_ready_o = !hold_i;
    assign accept    = s_valid_i && !hold_i;

    fb_addr_gen #(
        .FB_X      (FB_X),
        .FB_Y      (FB_Y),
        .ADDR_BITS (ADDR_BITS)
    ) u_addr_gen (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .cmd_i       (cmd),
        .x_in_line_o (x_in_line),
        .x_short_o   (x_short),
        .last_line_o (last_line),
        .addr_o      (cur_addr)
    );

    always_comb begin
        state_d   = state_q;
        cmd       = CMD_HOLD;
        wr_d      = 1'b0;
        wr_addr_d = cur_addr;
        fd_d      = 1'b0;
        err_set   = '0;
        case (state_q)
            IDLE: begin
                if (accept && s_sof_i) begin
                    wr_d      = 1'b1;
                    wr_addr_d = '0;
                    cmd       = CMD_RESTART;
                    state_d   = ACTIVE;
                end
            end
            ACTIVE: begin
                if (accept) begin
                    if (s_sof_i) begin
                        // SOF wins over a simultaneous EOL.
                        err_set[ERR_SOF_RESYNC] = 1'b1;
                        wr_d      = 1'b1;
                        wr_addr_d = '0;
                        cmd       = CMD_RESTART;
                    end else if (s_eol_i) begin
                        wr_d = x_in_line;
                        err_set[ERR_SHORT_LINE] = x_short;
                        if (last_line) begin
                            cmd     = CMD_FRAME_END;
                            fd_d    = 1'b1;
                            state_d = IDLE;
                        end else begin
                            cmd = CMD_NEXT_LINE;
                        end
                    end else if (x_in_line) begin
                        wr_d = 1'b1;
                        cmd  = CMD_STEP;
                    end else begin
                        err_set[ERR_LONG_LINE] = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // A new error in the clearing cycle still sticks.
        err_d = (err_clr_i ? '0 : err_q) | err_set;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            pxl_en_q   <= 1'b0;
            fd_q       <= 1'b0;
            err_q      <= '0;
            pxl_addr_q <= '0;
            pxl_data_q <= '0;
        end else begin
            state_q  <= state_d;
            pxl_en_q <= wr_d;
            fd_q     <= fd_d;
            err_q    <= err_d;
            if (wr_d) begin
                pxl_addr_q <= wr_addr_d;
                pxl_data_q <= s_data_i;
            end
        end
    end

    assign pxl_en_o     = pxl_en_q;
    assign pxl_addr_o   = pxl_addr_q;
    assign pxl_data_o   = pxl_data_q;
    assign frame_done_o = fd_q;
    assign err_o        = err_q;

endmodule
